// File: rtl/interface_hcsr04_if.sv
// -----------------------------------------------------------------------------
// interface_hcsr04_if
// Signal bundle between a measurement client and the HC-SR04 controller.
//
// Handshake (single comment for the whole bundle):
//   The client raises medir for one or more cycles while the controller is
//   idle. Each accepted request ends in exactly one one-cycle strobe: pronto
//   (medida has just been updated) or erro (timeout, medida unchanged).
//   Requests made while a measurement is in flight are dropped, not queued.
//   echo is the raw, asynchronous sensor line; trigger goes to the sensor.
//
// Signals:
//   medir      client -> ctrl  measurement request (level sampled)
//   echo       sensor -> ctrl  echo line (asynchronous)
//   trigger    ctrl -> sensor  trigger pulse
//   medida     ctrl -> client  distance, 3 BCD digits (hundreds/tens/units)
//   pronto     ctrl -> client  one-cycle strobe, medida updated
//   erro       ctrl -> client  one-cycle strobe, timeout
//   db_estado  ctrl -> client  current FSM state code
// -----------------------------------------------------------------------------
interface interface_hcsr04_if;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  modport slave (
    input  medir,
    input  echo,
    output trigger,
    output medida,
    output pronto,
    output erro,
    output db_estado
  );

  modport master (
    output medir,
    output echo,
    input  trigger,
    input  medida,
    input  pronto,
    input  erro,
    input  db_estado
  );
endinterface

// File: rtl/interface_hcsr04.sv
// -----------------------------------------------------------------------------
// interface_hcsr04
// HC-SR04 ultrasonic ranger controller. On request it emits a trigger pulse,
// waits for the echo, measures the echo width in centimetres (rounded to the
// nearest cm, saturating at 999) and presents the result as 3 BCD digits.
//
// Ports:
//   clock  system clock, all state changes on the rising edge
//   reset  asynchronous, active-high reset
//   bus    interface_hcsr04_if.slave: medir, echo, trigger, medida, pronto,
//          erro, db_estado
//
// Parameters:
//   CICLOS_TRIGGER  trigger pulse width in cycles
//   CICLOS_CM       echo cycles per centimetre
//   CICLOS_TIMEOUT  max wait for echo rise, and max echo width, in cycles
// -----------------------------------------------------------------------------
module interface_hcsr04 #(
  parameter int CICLOS_TRIGGER = 500,
  parameter int CICLOS_CM      = 2941,
  parameter int CICLOS_TIMEOUT = 1_500_000
) (
  input  logic               clock,
  input  logic               reset,
  interface_hcsr04_if.slave  bus
);

  localparam int CNT_MAX = (CICLOS_TIMEOUT > CICLOS_TRIGGER) ? CICLOS_TIMEOUT : CICLOS_TRIGGER;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(CICLOS_CM + 1);
  localparam int HALF    = (CICLOS_CM + 1) / 2;

  typedef enum logic [3:0] {
    S_INICIAL   = 4'h0,
    S_PREPARA   = 4'h1,
    S_TRIGGER   = 4'h2,
    S_ESPERA    = 4'h3,
    S_MEDE      = 4'h4,
    S_ARREDONDA = 4'h5,
    S_ARMAZENA  = 4'h6,
    S_FINAL     = 4'h7,
    S_ERRO      = 4'hF
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_count_echo;

  logic        r_echo_meta;
  logic        r_echo_s;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_res;
  logic [11:0] r_acc;
  logic [11:0] r_medida;
  logic        r_trigger;
  logic        r_pronto;
  logic        r_erro;

  // BCD +1 with saturation at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Two-flop synchronizer for the asynchronous echo line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
    end else begin
      r_echo_meta <= bus.echo;
      r_echo_s    <= r_echo_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_INICIAL;
    else       r_state <= w_next;
  end

  // FSM next state and counter control.
  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      S_INICIAL: begin
        w_cnt_clr = 1'b1;
        if (bus.medir) w_next = S_PREPARA;
      end
      S_PREPARA: begin
        w_cnt_clr = 1'b1;
        w_next    = S_TRIGGER;
      end
      S_TRIGGER: begin
        if (r_cnt == CW'(CICLOS_TRIGGER - 1)) begin
          w_cnt_clr = 1'b1;
          w_next    = S_ESPERA;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_ESPERA: begin
        if (r_echo_s) begin
          w_cnt_clr = 1'b1;
          w_next    = S_MEDE;
        end else if (r_cnt == CW'(CICLOS_TIMEOUT - 1)) begin
          w_cnt_clr = 1'b1;
          w_next    = S_ERRO;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_MEDE: begin
        if (!r_echo_s) begin
          w_next = S_ARREDONDA;
        end else if (r_cnt == CW'(CICLOS_TIMEOUT - 1)) begin
          w_next = S_ERRO;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_ARREDONDA: w_next = S_ARMAZENA;
      S_ARMAZENA:  w_next = S_FINAL;
      S_FINAL:     w_next = S_INICIAL;
      S_ERRO:      w_next = S_INICIAL;
      default:     w_next = S_INICIAL;
    endcase
  end

  // The ESPERA cycle that first sees echo_s high is counted as an echo cycle,
  // so the residual/accumulator pair covers the whole echo width exactly.
  assign w_count_echo = r_echo_s && ((r_state == S_ESPERA) || (r_state == S_MEDE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Residual counter and BCD accumulator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_res <= '0;
      r_acc <= 12'h000;
    end else if (r_state == S_PREPARA) begin
      r_res <= '0;
      r_acc <= 12'h000;
    end else if (w_count_echo) begin
      if (r_res == RW'(CICLOS_CM - 1)) begin
        r_res <= '0;
        r_acc <= bcd_inc(r_acc);
      end else begin
        r_res <= r_res + RW'(1);
      end
    end else if ((r_state == S_ARREDONDA) && (r_res >= RW'(HALF))) begin
      r_acc <= bcd_inc(r_acc);
    end
  end

  // Result register and strobes; strobes are decoded from the next state so
  // they are flop outputs aligned with the state they belong to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_medida  <= 12'h000;
      r_trigger <= 1'b0;
      r_pronto  <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      if (r_state == S_ARMAZENA) r_medida <= r_acc;
      r_trigger <= (w_next == S_TRIGGER);
      r_pronto  <= (w_next == S_FINAL);
      r_erro    <= (w_next == S_ERRO);
    end
  end

  assign bus.trigger   = r_trigger;
  assign bus.medida    = r_medida;
  assign bus.pronto    = r_pronto;
  assign bus.erro      = r_erro;
  assign bus.db_estado = r_state;

endmodule

// File: tb/tb_interface_hcsr04.sv
// -----------------------------------------------------------------------------
// tb_interface_hcsr04
// Directed bench for interface_hcsr04 with shortened timing parameters:
// trigger 5 cycles, 3 cycles per cm (round up from residual 2), timeout 3100.
// Expected distances: cm = N/3 + (N%3 >= 2), saturated at 999, in BCD.
// -----------------------------------------------------------------------------
module tb_interface_hcsr04;
  localparam int TRIG = 5;
  localparam int CM   = 3;
  localparam int TO   = 3100;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   pronto_cnt;
  int   erro_cnt;
  int   trig_cnt;

  interface_hcsr04_if bus ();

  interface_hcsr04 #(
    .CICLOS_TRIGGER (TRIG),
    .CICLOS_CM      (CM),
    .CICLOS_TIMEOUT (TO)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe / pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.pronto)  pronto_cnt++;
    if (bus.erro)    erro_cnt++;
    if (bus.trigger) trig_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request();
    bus.medir = 1'b1;
    step();
    bus.medir = 1'b0;
  endtask

  // Waits for the trigger pulse to start and end; optionally pulses medir
  // while the trigger is high.
  task automatic wait_trig(input string tag, input logic pulse);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.trigger) seen = 1'b1;
    end
    chk({tag, " trig_rise"}, {31'd0, seen}, 32'd1);
    if (pulse) begin
      bus.medir = 1'b1;
      step();
      bus.medir = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (!bus.trigger) seen = 1'b1;
    end
    chk({tag, " trig_fall"}, {31'd0, seen}, 32'd1);
  endtask

  // One measurement with an echo of n cycles.
  task automatic measure(input string tag, input int n, input logic pulse,
                         input logic exp_ok, input logic [11:0] exp_med);
    int   p0, e0, t0, lat;
    logic seen;
    p0 = pronto_cnt; e0 = erro_cnt; t0 = trig_cnt;
    request();
    wait_trig(tag, pulse);
    repeat (3) step();
    bus.echo = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.medir = pulse && (i == n / 2);
      step();
    end
    bus.medir = 1'b0;
    bus.echo  = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      lat++;
      if (bus.pronto) seen = 1'b1;
    end
    if (exp_ok) chk({tag, " latency"}, lat, 32'd5);
    repeat (4) step();
    chk({tag, " medida"}, {20'd0, bus.medida}, {20'd0, exp_med});
    chk({tag, " pronto_n"}, pronto_cnt - p0, exp_ok ? 32'd1 : 32'd0);
    chk({tag, " erro_n"}, erro_cnt - e0, exp_ok ? 32'd0 : 32'd1);
    chk({tag, " trig_w"}, trig_cnt - t0, TRIG);
    chk({tag, " idle"}, {28'd0, bus.db_estado}, 32'h0);
  endtask

  // Scoreboard: expected results of the measurement table.
  logic [11:0] exp_q[$];

  initial begin
    int n_tab[10];
    logic pulse_tab[10];
    int n, p0, e0;
    logic seen;
    logic [11:0] e;

    n_checks = 0; n_errors = 0;
    pronto_cnt = 0; erro_cnt = 0; trig_cnt = 0;
    bus.medir = 1'b0;
    bus.echo  = 1'b0;
    rst = 1'b1;
    repeat (3) step();

    chk("rst trigger", {31'd0, bus.trigger}, 32'd0);
    chk("rst pronto",  {31'd0, bus.pronto},  32'd0);
    chk("rst erro",    {31'd0, bus.erro},    32'd0);
    chk("rst medida",  {20'd0, bus.medida},  32'h000);
    chk("rst estado",  {28'd0, bus.db_estado}, 32'h0);
    rst = 1'b0;
    repeat (2) step();

    // Echo while idle is ignored.
    p0 = pronto_cnt; e0 = erro_cnt;
    bus.echo = 1'b1;
    repeat (5) step();
    chk("idle_echo estado", {28'd0, bus.db_estado}, 32'h0);
    bus.echo = 1'b0;
    repeat (10) step();
    chk("idle_echo strobes", (pronto_cnt - p0) + (erro_cnt - e0), 32'd0);

    // Echo widths and hand-computed results.
    n_tab = '{10, 11, 2, 1, 30, 299, 300, 2997, 2999, 3100};
    pulse_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_q.push_back(12'h003);  // 3 r1
    exp_q.push_back(12'h004);  // 3 r2 rounds up
    exp_q.push_back(12'h001);  // 0 r2 rounds up
    exp_q.push_back(12'h000);  // 0 r1
    exp_q.push_back(12'h010);  // carry into tens
    exp_q.push_back(12'h100);  // 99 r2 rounds into hundreds
    exp_q.push_back(12'h100);
    exp_q.push_back(12'h999);  // exactly 999
    exp_q.push_back(12'h999);  // rounding dropped at 999
    exp_q.push_back(12'h999);  // longest legal echo, saturated
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      measure($sformatf("meas%0d_n%0d", i, n_tab[i]), n_tab[i], pulse_tab[i], 1'b1, e);
    end

    // No echo: erro after TO+TRIG+2 edges from the request, medida held.
    p0 = pronto_cnt;
    bus.medir = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < TO + 100) begin
      step();
      n++;
      bus.medir = 1'b0;
      if (bus.erro) seen = 1'b1;
    end
    chk("noecho latency", n, TO + TRIG + 2);
    chk("noecho estado_f", {28'd0, bus.db_estado}, 32'hF);
    step();
    chk("noecho estado_0", {28'd0, bus.db_estado}, 32'h0);
    chk("noecho erro_off", {31'd0, bus.erro}, 32'd0);
    chk("noecho medida", {20'd0, bus.medida}, 32'h999);
    chk("noecho pronto_n", pronto_cnt - p0, 32'd0);
    repeat (3) step();

    // Echo one cycle too long: erro in MEDE, then a normal measurement.
    measure("long_echo", TO + 1, 1'b1, 1'b0, 12'h999);
    measure("after_long", 36, 1'b0, 1'b1, 12'h012);

    // Reset in the middle of an echo aborts with no strobe.
    p0 = pronto_cnt; e0 = erro_cnt;
    request();
    wait_trig("rst_mid", 1'b0);
    bus.echo = 1'b1;
    repeat (20) step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid trigger", {31'd0, bus.trigger}, 32'd0);
    chk("rst_mid pronto",  {31'd0, bus.pronto},  32'd0);
    chk("rst_mid erro",    {31'd0, bus.erro},    32'd0);
    chk("rst_mid medida",  {20'd0, bus.medida},  32'h000);
    chk("rst_mid estado",  {28'd0, bus.db_estado}, 32'h0);
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    bus.echo = 1'b0;
    repeat (20) step();
    chk("rst_mid strobes", (pronto_cnt - p0) + (erro_cnt - e0), 32'd0);
    chk("rst_mid idle", {28'd0, bus.db_estado}, 32'h0);
    measure("after_rst", 20, 1'b0, 1'b1, 12'h007);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
